// File: rtl/controlador_configuracion_pkg.sv
// Shared constants for the RTC display configuration path: display modes,
// cursor field positions and the highest cursor position per mode.
package controlador_configuracion_pkg;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_HORA   = 2'd1;
    localparam logic [1:0] MODE_FECHA  = 2'd2;
    localparam logic [1:0] MODE_TIMER  = 2'd3;

    localparam logic [1:0] CUR_DER  = 2'd0;
    localparam logic [1:0] CUR_MED  = 2'd1;
    localparam logic [1:0] CUR_IZQ  = 2'd2;
    localparam logic [1:0] CUR_AMPM = 2'd3;

    typedef enum logic [1:0] {
        ST_NORMAL = MODE_NORMAL,
        ST_HORA   = MODE_HORA,
        ST_FECHA  = MODE_FECHA,
        ST_TIMER  = MODE_TIMER
    } estado_t;

    // Only the time mode exposes the AM/PM field.
    function automatic logic [1:0] cmax(input logic [1:0] modo);
        return (modo == MODE_HORA) ? CUR_AMPM : CUR_IZQ;
    endfunction

endpackage

// File: rtl/controlador_configuracion_if.sv
// Button levels in, character-generator and RTC-write controls out.
interface controlador_configuracion_if;
    import controlador_configuracion_pkg::*;

    logic       btn_mode;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic [1:0] config_mode;
    logic [1:0] cursor_location;
    logic       parpadeo;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       commit_pulse;
    logic [1:0] commit_mode;
    logic       rtc_hold;

    modport master (
        output btn_mode, btn_left, btn_right, btn_up, btn_down,
        input  config_mode, cursor_location, parpadeo, inc_pulse, dec_pulse,
               commit_pulse, commit_mode, rtc_hold
    );

    modport slave (
        input  btn_mode, btn_left, btn_right, btn_up, btn_down,
        output config_mode, cursor_location, parpadeo, inc_pulse, dec_pulse,
               commit_pulse, commit_mode, rtc_hold
    );

endinterface

// File: rtl/controlador_configuracion_boton_flanco.sv
// Two-flop synchronizer followed by a registered rising-edge pulse; a press
// sampled at edge k shows up as pulso_o after edge k+2.
module boton_flanco (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulso_o
);
    logic s1_q, s2_q, s3_q, pulso_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            pulso_q <= 1'b0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pulso_q <= s2_q & ~s3_q;
        end
    end

    assign pulso_o = pulso_q;

endmodule

// File: rtl/controlador_configuracion.sv
// Configuration sequencer: button edges drive mode/cursor selection, field
// edit strobes, the blink phase and the inactivity timeout with commit.
module controlador_configuracion
    import controlador_configuracion_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BLINK_HZ  = 2,
    parameter int TIMEOUT_S = 30
) (
    input logic                        clk,
    input logic                        reset,
    controlador_configuracion_if.slave bus
);
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int TO_HALFS  = TIMEOUT_S * 2 * BLINK_HZ;
    localparam int BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int TW        = $clog2(TO_HALFS + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TO_HALFS - 1);
    localparam logic [TW-1:0] TO_MAX     = TW'(TO_HALFS);

    logic [4:0] btn_lvl, flanco;
    assign btn_lvl = {bus.btn_down, bus.btn_up, bus.btn_right, bus.btn_left, bus.btn_mode};

    boton_flanco u_flanco [4:0] (
        .clk    (clk),
        .rst_n  (reset),
        .btn_i  (btn_lvl),
        .pulso_o(flanco)
    );

    logic e_mode, e_left, e_right, e_up, e_down;
    assign {e_down, e_up, e_right, e_left, e_mode} = flanco;

    estado_t       state_q;
    logic [1:0]    cursor_q;
    logic [BW-1:0] blink_q;
    logic [TW-1:0] halfs_q, halfs_d;
    logic          parp_q, inc_q, dec_q, commit_q;
    logic [1:0]    commit_mode_q;

    logic       in_cfg, half_done, timeout, lr_ok, ud_ok;
    logic [1:0] cmax_cur, cur_left, cur_right;

    assign in_cfg    = (state_q != ST_NORMAL);
    assign half_done = in_cfg && (blink_q == BLINK_LAST);
    assign timeout   = half_done && (halfs_q >= TO_LAST);
    assign halfs_d   = (halfs_q == TO_MAX) ? halfs_q : halfs_q + 1'b1;
    // Opposing buttons in the same cycle cancel; any cursor edge masks edits.
    assign lr_ok     = e_left ^ e_right;
    assign ud_ok     = (e_up ^ e_down) && !(e_left || e_right);
    assign cmax_cur  = cmax(state_q);
    assign cur_left  = (cursor_q == cmax_cur) ? CUR_DER : cursor_q + 2'd1;
    assign cur_right = (cursor_q == CUR_DER) ? cmax_cur : cursor_q - 2'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_NORMAL;
            cursor_q      <= CUR_DER;
            blink_q       <= '0;
            halfs_q       <= '0;
            parp_q        <= 1'b0;
            inc_q         <= 1'b0;
            dec_q         <= 1'b0;
            commit_q      <= 1'b0;
            commit_mode_q <= MODE_NORMAL;
        end else begin
            inc_q         <= 1'b0;
            dec_q         <= 1'b0;
            commit_q      <= 1'b0;
            commit_mode_q <= MODE_NORMAL;
            if (e_mode) begin
                case (state_q)
                    ST_NORMAL: state_q <= ST_HORA;
                    ST_HORA:   state_q <= ST_FECHA;
                    ST_FECHA:  state_q <= ST_TIMER;
                    default:   state_q <= ST_NORMAL;
                endcase
                commit_q      <= in_cfg;
                commit_mode_q <= in_cfg ? state_q : MODE_NORMAL;
                cursor_q      <= (state_q == ST_TIMER) ? CUR_DER : CUR_IZQ;
                blink_q       <= '0;
                halfs_q       <= '0;
                parp_q        <= 1'b0;
            end else if (!in_cfg) begin
                cursor_q <= CUR_DER;
                blink_q  <= '0;
                halfs_q  <= '0;
                parp_q   <= 1'b0;
            end else if (lr_ok || ud_ok) begin
                // Show the edited field solid and restart the inactivity window.
                if (lr_ok) cursor_q <= e_left ? cur_left : cur_right;
                else begin
                    inc_q <= e_up;
                    dec_q <= e_down;
                end
                blink_q <= '0;
                halfs_q <= '0;
                parp_q  <= 1'b0;
            end else if (timeout) begin
                state_q       <= ST_NORMAL;
                commit_q      <= 1'b1;
                commit_mode_q <= state_q;
                cursor_q      <= CUR_DER;
                blink_q       <= '0;
                halfs_q       <= '0;
                parp_q        <= 1'b0;
            end else if (half_done) begin
                blink_q <= '0;
                halfs_q <= halfs_d;
                parp_q  <= ~parp_q;
            end else begin
                blink_q <= blink_q + 1'b1;
            end
        end
    end

    assign bus.config_mode     = state_q;
    assign bus.cursor_location = cursor_q;
    assign bus.parpadeo        = parp_q;
    assign bus.inc_pulse       = inc_q;
    assign bus.dec_pulse       = dec_q;
    assign bus.commit_pulse    = commit_q;
    assign bus.commit_mode     = commit_mode_q;
    assign bus.rtc_hold        = in_cfg;

endmodule

// File: tb/tb_controlador_configuracion.sv
// Bench for the configuration sequencer: a cycle-level reference model checks
// every cycle, plus a vector table and directed timing sequences.
module tb_controlador_configuracion;

    localparam int CLK_HZ    = 8;
    localparam int BLINK_HZ  = 1;
    localparam int TIMEOUT_S = 2;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int TO_CLKS   = TIMEOUT_S * 2 * BLINK_HZ * BLINK_DIV;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    controlador_configuracion_if bus ();

    controlador_configuracion #(
        .CLK_HZ   (CLK_HZ),
        .BLINK_HZ (BLINK_HZ),
        .TIMEOUT_S(TIMEOUT_S)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int ntests = 0;
    int nfail  = 0;

    // Reference model state: history of sampled levels, mode, cursor and the
    // number of clocks since the blink/timeout window last restarted.
    logic [4:0] hist [4];
    int m_mode, m_cur, m_t, m_inc, m_dec, m_com, m_cm;
    int n_com, n_inc, n_dec, last_cm;

    task automatic chk(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) hist[i] = '0;
        m_mode = 0; m_cur = 0; m_t = 0;
        m_inc = 0; m_dec = 0; m_com = 0; m_cm = 0;
    endtask

    task automatic model_step();
        logic [4:0] s, ev;
        int cm;
        s = {bus.btn_down, bus.btn_up, bus.btn_right, bus.btn_left, bus.btn_mode};
        if (!reset) begin
            model_clear();
            return;
        end
        ev = hist[2] & ~hist[3];
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = s;
        m_inc = 0; m_dec = 0; m_com = 0; m_cm = 0;
        cm = (m_mode == 1) ? 3 : 2;
        if (ev[0]) begin
            if (m_mode != 0) begin m_com = 1; m_cm = m_mode; end
            m_mode = (m_mode + 1) % 4;
            m_cur  = (m_mode != 0) ? 2 : 0;
            m_t    = 0;
        end else if (m_mode == 0) begin
            m_cur = 0; m_t = 0;
        end else if (ev[1] != ev[2]) begin
            m_cur = ev[1] ? (m_cur + 1) % (cm + 1) : (m_cur + cm) % (cm + 1);
            m_t   = 0;
        end else if (!ev[1] && !ev[2] && (ev[3] != ev[4])) begin
            m_inc = ev[3]; m_dec = ev[4]; m_t = 0;
        end else begin
            m_t++;
            if (m_t == TO_CLKS) begin
                m_com = 1; m_cm = m_mode; m_mode = 0; m_cur = 0; m_t = 0;
            end
        end
    endtask

    function automatic logic [10:0] act_vec();
        return {bus.config_mode, bus.cursor_location, bus.parpadeo, bus.inc_pulse,
                bus.dec_pulse, bus.commit_pulse, bus.commit_mode, bus.rtc_hold};
    endfunction

    function automatic logic [10:0] exp_vec();
        logic p;
        p = (m_mode != 0) ? 1'((m_t / BLINK_DIV) % 2) : 1'b0;
        return {2'(m_mode), 2'(m_cur), p, 1'(m_inc), 1'(m_dec), 1'(m_com), 2'(m_cm),
                1'(m_mode != 0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model_outputs", int'(act_vec()), int'(exp_vec()));
        if (bus.commit_pulse) begin n_com++; last_cm = bus.commit_mode; end
        if (bus.inc_pulse) n_inc++;
        if (bus.dec_pulse) n_dec++;
    endtask

    task automatic set_btns(input logic [4:0] b);
        {bus.btn_down, bus.btn_up, bus.btn_right, bus.btn_left, bus.btn_mode} = b;
    endtask

    task automatic press(input logic [4:0] b);
        set_btns(b);
        tick();
        set_btns(5'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        set_btns(5'b0);
        tick(); tick();
        reset = 1'b1;
    endtask

    typedef struct {
        logic [4:0] btn;   // {down, up, right, left, mode}
        int hold, e_mode, e_cur, e_ncom, e_cm, e_ninc, e_ndec;
    } vec_t;

    vec_t tbl [17];
    logic [4:0] lvl;

    initial begin
        model_clear();
        set_btns(5'b0);
        n_com = 0; n_inc = 0; n_dec = 0; last_cm = 0;

        tbl[0]  = '{5'b00001,  1, 1, 2, 0, 0, 0, 0};
        tbl[1]  = '{5'b00010,  1, 1, 3, 0, 0, 0, 0};
        tbl[2]  = '{5'b00010,  1, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{5'b00100,  1, 1, 3, 0, 0, 0, 0};
        tbl[4]  = '{5'b00001,  1, 2, 2, 1, 1, 0, 0};
        tbl[5]  = '{5'b00010,  1, 2, 0, 0, 0, 0, 0};
        tbl[6]  = '{5'b00100,  1, 2, 2, 0, 0, 0, 0};
        tbl[7]  = '{5'b00001,  1, 3, 2, 1, 2, 0, 0};
        tbl[8]  = '{5'b01000, 10, 3, 2, 0, 0, 1, 0};
        tbl[9]  = '{5'b10000,  1, 3, 2, 0, 0, 0, 1};
        tbl[10] = '{5'b00110,  1, 3, 2, 0, 0, 0, 0};
        tbl[11] = '{5'b01001,  1, 0, 0, 1, 3, 0, 0};
        tbl[12] = '{5'b01000,  1, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{5'b10000,  1, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{5'b00001,  1, 1, 2, 0, 0, 0, 0};
        tbl[15] = '{5'b11000,  1, 1, 2, 0, 0, 0, 0};
        tbl[16] = '{5'b01010,  1, 1, 3, 0, 0, 0, 0};

        // Reset state and the three-edge latency of a mode press.
        do_reset();
        chk("reset_outputs", int'(act_vec()), 0);
        set_btns(5'b00001);
        tick();
        set_btns(5'b0);
        chk("lat_k", bus.config_mode, 0);
        tick();
        chk("lat_k1", bus.config_mode, 0);
        tick();
        chk("lat_k2", bus.config_mode, 0);
        tick();
        chk("lat_k3_mode", bus.config_mode, 1);
        chk("lat_k3_cursor", bus.cursor_location, 2);

        // Vector table from a fresh reset.
        do_reset();
        foreach (tbl[i]) begin
            n_com = 0; n_inc = 0; n_dec = 0; last_cm = 0;
            set_btns(tbl[i].btn);
            repeat (tbl[i].hold) tick();
            set_btns(5'b0);
            repeat (5) tick();
            chk($sformatf("tbl%0d_mode", i), bus.config_mode, tbl[i].e_mode);
            chk($sformatf("tbl%0d_cursor", i), bus.cursor_location, tbl[i].e_cur);
            chk($sformatf("tbl%0d_ncommit", i), n_com, tbl[i].e_ncom);
            if (tbl[i].e_ncom > 0)
                chk($sformatf("tbl%0d_commit_mode", i), last_cm, tbl[i].e_cm);
            chk($sformatf("tbl%0d_ninc", i), n_inc, tbl[i].e_ninc);
            chk($sformatf("tbl%0d_ndec", i), n_dec, tbl[i].e_ndec);
        end

        // Blink phase in FECHA, then a left press forcing it visible.
        do_reset();
        press(5'b00001);
        repeat (5) tick();
        press(5'b00001);
        tick(); tick(); tick();
        chk("blink_fecha", bus.config_mode, 2);
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("blink_e%0d", i), bus.parpadeo, (i / 4) % 2);
        end
        press(5'b00010);
        tick(); tick();
        chk("blink_pre_left", bus.parpadeo, 1);
        tick();
        chk("blink_forced", bus.parpadeo, 0);
        chk("blink_left_cursor", bus.cursor_location, 0);
        tick(); tick(); tick();
        chk("blink_restart_low", bus.parpadeo, 0);
        tick();
        chk("blink_restart_high", bus.parpadeo, 1);

        // Asynchronous reset mid-edit: outputs clear at once, nothing committed.
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("rst_mid_outputs", int'(act_vec()), 0);
        model_clear();
        n_com = 0;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("rst_mid_ncommit", n_com, 0);

        // Inactivity timeout in HORA.
        do_reset();
        press(5'b00001);
        tick(); tick(); tick();
        repeat (TO_CLKS - 1) tick();
        chk("to_before_mode", bus.config_mode, 1);
        chk("to_before_commit", bus.commit_pulse, 0);
        tick();
        chk("to_mode", bus.config_mode, 0);
        chk("to_commit", bus.commit_pulse, 1);
        chk("to_commit_mode", bus.commit_mode, 1);
        tick();
        chk("to_commit_one_cycle", bus.commit_pulse, 0);

        // Mode press landing on the timeout edge: advance once, single commit.
        do_reset();
        press(5'b00001);
        tick(); tick(); tick();
        repeat (TO_CLKS - 4) tick();
        n_com = 0;
        press(5'b00001);
        tick(); tick();
        chk("tomode_before", bus.config_mode, 1);
        tick();
        chk("tomode_mode", bus.config_mode, 2);
        chk("tomode_commit_mode", bus.commit_mode, 1);
        repeat (4) tick();
        chk("tomode_ncommit", n_com, 1);

        // Random button activity against the model.
        do_reset();
        lvl = '0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(23) == 0) lvl[0] = ~lvl[0];
            for (int b = 1; b < 5; b++)
                if ($urandom_range(5) == 0) lvl[b] = ~lvl[b];
            set_btns(lvl);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/controlador_configuracion.md
Name: controlador_configuracion

Overview:
Configuration sequencer for the RTC VGA display. It turns debounced push-button levels into the `config_mode`, `cursor_location` and `parpadeo` inputs of the character generator. It also issues one-cycle increment/decrement strobes and a commit strobe toward the RTC register interface. It sits between the button debouncers and both the character generator and the RTC write controller.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BLINK_HZ, 2, full blink frequency of `parpadeo`. Half-period BLINK_DIV = CLK_HZ/(2*BLINK_HZ) clocks.
- TIMEOUT_S, 30, inactivity time in config mode before automatic exit. Limit TO_HALFS = TIMEOUT_S*2*BLINK_HZ blink half-periods.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_mode  in  1  debounced level, cycles through config modes.
- btn_left  in  1  debounced level, moves cursor one field left.
- btn_right  in  1  debounced level, moves cursor one field right.
- btn_up  in  1  debounced level, increments the selected field.
- btn_down  in  1  debounced level, decrements the selected field.
- config_mode  out  2  0 normal, 1 config hora, 2 config fecha, 3 config timer.
- cursor_location  out  2  0 right pair, 1 middle pair, 2 left pair, 3 AM/PM (mode 1 only).
- parpadeo  out  1  blink phase; 1 blanks the selected field.
- inc_pulse  out  1  one-cycle strobe, increment field (config_mode, cursor_location).
- dec_pulse  out  1  one-cycle strobe, decrement field (config_mode, cursor_location).
- commit_pulse  out  1  one-cycle strobe on leaving a config mode.
- commit_mode  out  2  mode being committed; valid while commit_pulse=1.
- rtc_hold  out  1  high whenever config_mode != 0 (freezes RTC readback).

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0, FSM in NORMAL.
  - Synchronizers, blink counter and timeout counter cleared.
  - Reset mid-edit discards the edit: no commit_pulse.
- Button input path:
  - Each button passes a 2-FF synchronizer, then rising-edge detection.
  - An edge is a synced value going 0->1.
  - Input high sampled at clk edge k produces the resulting output change or strobe at edge k+3.
  - A held button produces exactly one event.
- FSM states: NORMAL(0), HORA(1), FECHA(2), TIMER(3). The state drives config_mode directly.
- On a mode edge:
  - NORMAL->HORA->FECHA->TIMER->NORMAL.
  - Entering any config state sets cursor_location=2.
  - Leaving HORA/FECHA/TIMER (to the next config state or to NORMAL) asserts commit_pulse for 1 cycle, with commit_mode = state being left.
  - The commit is registered in the same cycle as the state change.
- Cursor (config states only):
  - CMAX = 3 in HORA, 2 in FECHA and TIMER.
  - Left edge: cursor+1; CMAX wraps to 0.
  - Right edge: cursor-1; 0 wraps to CMAX.
  - In NORMAL, cursor_location is held at 0.
- Edit strobes:
  - Up edge gives inc_pulse; down edge gives dec_pulse.
  - Config states only; ignored in NORMAL.
- Simultaneous edges in one cycle:
  - Priority: mode > left/right > up/down; lower-priority edges that cycle are dropped.
  - Left+right together: both ignored. Up+down together: both ignored.
- Blink:
  - In NORMAL, parpadeo=0 and the blink counter is held at 0.
  - In config states, parpadeo toggles every BLINK_DIV clocks.
  - Any accepted button event forces parpadeo=0 and restarts the counter, so the edited value is visible immediately.
- Timeout:
  - Counts completed blink half-periods in config states; cleared by any accepted button event.
  - On reaching TO_HALFS: go to NORMAL, commit_pulse=1 with commit_mode = current state.
  - If timeout and a mode edge coincide, only the mode edge is acted on (single commit).
- Widths:
  - Blink counter is $clog2(BLINK_DIV) bits.
  - Timeout counter is $clog2(TO_HALFS+1) bits; saturating, no wrap.
- inc_pulse, dec_pulse and commit_pulse are never high for 2 consecutive cycles and are mutually exclusive.

Decomposition:
- Shared package holds:
  - Mode constants MODE_NORMAL=2'd0, MODE_HORA=2'd1, MODE_FECHA=2'd2, MODE_TIMER=2'd3.
  - Cursor constants CUR_DER=0, CUR_MED=1, CUR_IZQ=2, CUR_AMPM=3.
  - CMAX per mode.
- These constants are also consumed by the character generator and the RTC write controller.
- One sub-module, boton_flanco: 2-FF synchronizer plus rising-edge pulse, async active-low reset, instantiated 5 times.

Test Plan (CLK_HZ=8, BLINK_HZ=1 so BLINK_DIV=4; TIMEOUT_S=2 so TO_HALFS=4, i.e. 16 clocks):
- Reset/mode cycle: release reset, pulse btn_mode 4 times.
  - config_mode goes 1,2,3,0; cursor=2 on each entry.
  - commit_pulse with commit_mode 1, 2, 3 on the 2nd, 3rd and 4th press; 3-cycle latency per press.
- Cursor wrap: in HORA from cursor 2, press left 2 times -> 3, then 0. Press right -> 3. In FECHA from 0, press right -> 2.
- Edits: in TIMER, press up, hold it 10 cycles, then press down.
  - Exactly one inc_pulse and one dec_pulse.
  - In NORMAL, up/down produce no pulses.
- Blink/visibility: in FECHA, parpadeo toggles every 4 clocks. A left press forces parpadeo=0 and restarts the 4-clock phase.
- Timeout: enter HORA, no input.
  - At 16 clocks after the last event: config_mode=0, commit_pulse=1 with commit_mode=1.
  - A mode press landing on the timeout cycle gives FECHA and a single commit.
- Conflicts/reset: left+right in the same cycle -> cursor unchanged. mode+up together -> mode advances, no inc_pulse. reset asserted mid-FECHA -> all outputs 0 immediately, no commit_pulse.
